// File: rtl/cfg_pkg.sv
// cfg_pkg: shared definitions for the serial configuration loader.
//   cfg_state_e : loader FSM states
//   START_BIT   : value of the bit that opens a frame
//   frame_len() : accepted bits per frame (start + index + payload + parity)
package cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IDX,
        ST_DATA,
        ST_PAR,
        ST_WRITE
    } cfg_state_e;

    localparam logic START_BIT = 1'b1;

    function automatic int frame_len(input int idx_w, input int cfg_w);
        return 1 + idx_w + cfg_w + 1;
    endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// cfg_shift_reg: MSB-first serial-in shift register with a running parity.
//   clk_i      : clock
//   clr_i      : clears contents and parity (takes priority over shift)
//   shift_en_i : shift bit_i in at the LSB end
//   bit_i      : serial input bit
//   data_o     : W-bit register contents, first bit shifted in ends up at the MSB
//   par_o      : XOR of every bit shifted in since the last clear
module cfg_shift_reg #(
    parameter int W = 20
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         shift_en_i,
    input  logic         bit_i,
    output logic [W-1:0] data_o,
    output logic         par_o
);

    logic [W-1:0] data_q, data_d;
    logic         par_q, par_d;

    always_comb begin
        data_d = data_q;
        par_d  = par_q;
        if (clr_i) begin
            data_d = '0;
            par_d  = 1'b0;
        end else if (shift_en_i) begin
            data_d = {data_q[W-2:0], bit_i};
            par_d  = par_q ^ bit_i;
        end
    end

    // Datapath only: the loader clears it at every start bit, so no reset is needed.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
        par_q  <= par_d;
    end

    assign data_o = data_q;
    assign par_o  = par_q;

endmodule

// File: rtl/cfg_loader.sv
// cfg_loader: deframes a bit-serial configuration stream and writes one
// CFG_W-bit word to the addressed block with a one-cycle one-hot strobe.
//   clk_i, reset_i : clock, synchronous active-high reset
//   bit_i, valid_i : serial stream bit and its qualifier
//   ready_o        : a bit is accepted this cycle when valid_i && ready_o
//   wr_en_o        : one-hot write strobe, one bit per target block
//   bits_o         : last written payload, stable between writes
//   err_o          : one-cycle pulse for a rejected frame (parity or index)
//   busy_o         : a frame is in progress
//   wr_cnt_o       : successful write count, saturating at 255
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int CFG_W   = 18,
    parameter int NUM_BLK = 4,
    parameter int IDX_W   = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               bit_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [NUM_BLK-1:0] wr_en_o,
    output logic [CFG_W-1:0]   bits_o,
    output logic               err_o,
    output logic               busy_o,
    output logic [7:0]         wr_cnt_o
);

    localparam int SR_W  = IDX_W + CFG_W;
    localparam int MAX_W = (IDX_W > CFG_W) ? IDX_W : CFG_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    localparam logic [CNT_W-1:0] IDX_LAST  = CNT_W'(IDX_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(CFG_W - 1);
    // One extra bit so NUM_BLK == 2**IDX_W is representable.
    localparam logic [IDX_W:0]   BLK_LIMIT = (IDX_W + 1)'(NUM_BLK);

    cfg_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_BLK-1:0] wr_en_q, wr_en_d;
    logic [CFG_W-1:0]   bits_q, bits_d;
    logic               err_q, err_d;
    logic [7:0]         wr_cnt_q, wr_cnt_d;

    logic               accept;
    logic               sr_clr, sr_shift;
    logic [SR_W-1:0]    sr_data;
    logic               sr_par;
    logic [IDX_W-1:0]   frame_idx;
    logic [CFG_W-1:0]   frame_pay;

    // Index and payload share one shift register; the index lands in the top bits.
    cfg_shift_reg #(.W(SR_W)) u_sr (
        .clk_i      (clk_i),
        .clr_i      (sr_clr),
        .shift_en_i (sr_shift),
        .bit_i      (bit_i),
        .data_o     (sr_data),
        .par_o      (sr_par)
    );

    assign frame_idx = sr_data[SR_W-1:CFG_W];
    assign frame_pay = sr_data[CFG_W-1:0];
    assign accept    = valid_i && (state_q != ST_WRITE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_en_d  = '0;
        err_d    = 1'b0;
        bits_d   = bits_q;
        wr_cnt_d = wr_cnt_q;
        sr_clr   = 1'b0;
        sr_shift = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Zeros here are line padding and are simply dropped.
                if (accept && bit_i == START_BIT) begin
                    state_d = ST_IDX;
                    cnt_d   = '0;
                    sr_clr  = 1'b1;
                end
            end
            ST_IDX: begin
                if (accept) begin
                    sr_shift = 1'b1;
                    if (cnt_q == IDX_LAST) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    sr_shift = 1'b1;
                    if (cnt_q == DATA_LAST) begin
                        state_d = ST_PAR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PAR: begin
                if (accept) begin
                    cnt_d = '0;
                    // Strobe, payload and count are registered here so they are
                    // all visible during the single WRITE cycle.
                    if ((sr_par ^ bit_i) == 1'b0 && {1'b0, frame_idx} < BLK_LIMIT) begin
                        state_d = ST_WRITE;
                        wr_en_d = NUM_BLK'(1) << frame_idx;
                        bits_d  = frame_pay;
                        if (wr_cnt_q != 8'hFF) begin
                            wr_cnt_d = wr_cnt_q + 8'd1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wr_en_q  <= '0;
            bits_q   <= '0;
            err_q    <= 1'b0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_en_q  <= wr_en_d;
            bits_q   <= bits_d;
            err_q    <= err_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign ready_o  = (state_q != ST_WRITE);
    assign busy_o   = (state_q != ST_IDLE);
    assign wr_en_o  = wr_en_q;
    assign bits_o   = bits_q;
    assign err_o    = err_q;
    assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader: randomized frame-level bench for cfg_loader. A default
// instance (NUM_BLK=4) carries most traffic; a NUM_BLK=3 instance covers the
// out-of-range index case.
module tb_cfg_loader;

    localparam int CFG_W = 18;
    localparam int IDX_W = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              bit_a = 1'b0, valid_a = 1'b0;
    logic              ready_a, err_a, busy_a;
    logic [3:0]        wr_en_a;
    logic [CFG_W-1:0]  bits_a;
    logic [7:0]        wr_cnt_a;
    logic              bit_b = 1'b0, valid_b = 1'b0;
    logic              ready_b, err_b, busy_b;
    logic [2:0]        wr_en_b;
    logic [CFG_W-1:0]  bits_b;
    logic [7:0]        wr_cnt_b;

    always #5 clk = ~clk;

    cfg_loader #(.CFG_W(CFG_W), .NUM_BLK(4)) dut (
        .clk_i(clk), .reset_i(reset), .bit_i(bit_a), .valid_i(valid_a),
        .ready_o(ready_a), .wr_en_o(wr_en_a), .bits_o(bits_a), .err_o(err_a),
        .busy_o(busy_a), .wr_cnt_o(wr_cnt_a)
    );

    cfg_loader #(.CFG_W(CFG_W), .NUM_BLK(3)) dut3 (
        .clk_i(clk), .reset_i(reset), .bit_i(bit_b), .valid_i(valid_b),
        .ready_o(ready_b), .wr_en_o(wr_en_b), .bits_o(bits_b), .err_o(err_b),
        .busy_o(busy_b), .wr_cnt_o(wr_cnt_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed events, collected away from the active edge.
    typedef struct {
        logic [3:0]       en;
        logic [CFG_W-1:0] bits;
        logic [7:0]       cnt;
        time              t;
    } strobe_t;

    strobe_t sq[$];
    time     eq_t[$];
    int      s3_cnt = 0;
    int      e3_cnt = 0;
    time     t_acc;

    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en_a != 4'b0000) begin
                check("onehot", $countones(wr_en_a), 1);
                sq.push_back('{en: wr_en_a, bits: bits_a, cnt: wr_cnt_a, t: $time});
            end
            if (err_a) eq_t.push_back($time);
            if (wr_en_b != 3'b000) s3_cnt++;
            if (err_b) e3_cnt++;
        end
    end

    // Reference model: the last accepted payload and the saturating write count.
    logic [CFG_W-1:0] exp_bits = '0;
    int               exp_cnt  = 0;

    function automatic bit frame_ok(input logic [1:0] idx, input logic [CFG_W-1:0] pay,
                                    input logic par, input int nblk);
        return ((^{idx, pay, par}) == 1'b0) && (int'(idx) < nblk);
    endfunction

    task automatic send_bit(input int sel, input logic b, input bit stall);
        logic rdy;
        int   guard;
        if (stall) begin
            if (sel == 0) valid_a = 1'b0; else valid_b = 1'b0;
            @(posedge clk); #1;
        end
        if (sel == 0) begin bit_a = b; valid_a = 1'b1; end
        else begin bit_b = b; valid_b = 1'b1; end
        guard = 0;
        while (1) begin
            rdy = (sel == 0) ? ready_a : ready_b;
            @(posedge clk);
            if (rdy) begin
                t_acc = $time;
                break;
            end
            #1;
            guard++;
            if (guard > 50) begin
                $display("FAIL ready_timeout: got 0 expected 1");
                $fatal(1, "ready never returned");
            end
        end
        #1;
        if (sel == 0) valid_a = 1'b0; else valid_b = 1'b0;
    endtask

    // mode: 0 back-to-back, 1 stall before every bit, 2 random stalls
    task automatic send_frame(input int sel, input logic [1:0] idx, input logic [CFG_W-1:0] pay,
                              input logic par, input int pad, input int mode);
        bit st;
        for (int i = 0; i < pad + 1 + IDX_W + CFG_W + 1; i++) begin
            logic b;
            if (i < pad) b = 1'b0;
            else if (i == pad) b = 1'b1;
            else if (i < pad + 1 + IDX_W) b = idx[IDX_W - 1 - (i - pad - 1)];
            else if (i < pad + 1 + IDX_W + CFG_W) b = pay[CFG_W - 1 - (i - pad - 1 - IDX_W)];
            else b = par;
            st = (mode == 1) ? 1'b1 : (mode == 2) ? bit'($urandom_range(0, 1)) : 1'b0;
            send_bit(sel, b, st);
        end
    endtask

    task automatic run_frame(input logic [1:0] idx, input logic [CFG_W-1:0] pay,
                             input logic par, input int pad, input int mode);
        bit  good;
        time tp;
        sq.delete();
        eq_t.delete();
        send_frame(0, idx, pay, par, pad, mode);
        tp = t_acc;
        repeat (3) @(posedge clk);
        #1;
        good = frame_ok(idx, pay, par, 4);
        if (good) begin
            exp_bits = pay;
            if (exp_cnt < 255) exp_cnt++;
        end
        check("strobe_count", sq.size(), good);
        check("err_count", eq_t.size(), !good);
        if (good && sq.size() == 1) begin
            check("wr_en", sq[0].en, 4'b0001 << idx);
            check("wr_bits", sq[0].bits, pay);
            check("wr_cnt_at_strobe", sq[0].cnt, exp_cnt);
            check("wr_latency", 32'(sq[0].t - tp), 5);
        end
        if (!good && eq_t.size() == 1) check("err_latency", 32'(eq_t[0] - tp), 5);
        check("bits_hold", bits_a, exp_bits);
        check("wr_cnt", wr_cnt_a, exp_cnt);
        check("busy_after", busy_a, 0);
    endtask

    task automatic do_reset();
        valid_a = 1'b0;
        valid_b = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_bits = '0;
        exp_cnt  = 0;
    endtask

    logic [1:0]       ridx;
    logic [CFG_W-1:0] rpay;
    logic             rpar;
    logic [1:0]       ei[$];
    logic [CFG_W-1:0] ep[$];

    initial begin
        do_reset();
        check("rst_wr_en", wr_en_a, 0);
        check("rst_bits", bits_a, 0);
        check("rst_err", err_a, 0);
        check("rst_wr_cnt", wr_cnt_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_ready", ready_a, 1);

        // Basic write, then the same frame with the wrong parity.
        run_frame(2'b10, 18'b111111000000000000, 1'b1, 0, 0);
        run_frame(2'b10, 18'b111111000000000000, 1'b0, 0, 0);

        // Padding zeros and valid dropped every other cycle.
        rpay = 18'b001001010000000010;
        run_frame(2'b00, rpay, ^{2'b00, rpay}, 5, 1);

        // Out-of-range index on the three-block instance, then an in-range one.
        rpay = 18'($urandom);
        send_frame(1, 2'b11, rpay, ^{2'b11, rpay}, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("oor_strobes", s3_cnt, 0);
        check("oor_err", e3_cnt, 1);
        check("oor_bits", bits_b, 0);
        send_frame(1, 2'b10, rpay, ^{2'b10, rpay}, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("blk3_strobes", s3_cnt, 1);
        check("blk3_bits", bits_b, rpay);

        // Reset after 10 payload bits, then a complete frame to block 1.
        sq.delete();
        send_bit(0, 1'b1, 0);
        send_bit(0, 1'b0, 0);
        send_bit(0, 1'b1, 0);
        for (int i = 0; i < 10; i++) send_bit(0, 1'($urandom), 0);
        check("busy_mid_frame", busy_a, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_bits = '0;
        exp_cnt  = 0;
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_bits", bits_a, 0);
        check("mid_rst_cnt", wr_cnt_a, 0);
        check("mid_rst_no_strobe", sq.size(), 0);
        rpay = 18'($urandom);
        run_frame(2'b01, rpay, ^{2'b01, rpay}, 0, 0);

        // Randomized frames: mostly good, some bad parity, random padding and stalls.
        for (int k = 0; k < 40; k++) begin
            ridx = 2'($urandom);
            rpay = 18'($urandom);
            rpar = ^{ridx, rpay};
            if ($urandom_range(0, 3) == 0) rpar = ~rpar;
            run_frame(ridx, rpay, rpar, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Throughput and counter saturation.
        do_reset();
        sq.delete();
        for (int k = 0; k < 260; k++) begin
            ridx = 2'($urandom);
            rpay = 18'($urandom);
            ei.push_back(ridx);
            ep.push_back(rpay);
            send_frame(0, ridx, rpay, ^{ridx, rpay}, 0, 0);
        end
        repeat (3) @(posedge clk);
        #1;
        check("tp_strobes", sq.size(), 260);
        for (int k = 0; k < 260 && k < sq.size(); k++) begin
            check("tp_en", sq[k].en, 4'b0001 << ei[k]);
            check("tp_bits", sq[k].bits, ep[k]);
            check("tp_cnt", sq[k].cnt, (k + 1 > 255) ? 255 : k + 1);
            if (k > 0) check("tp_spacing", 32'(sq[k].t - sq[k-1].t), 230);
        end
        check("tp_sat", wr_cnt_a, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
